multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Moore/Mealy FSM that sequences a shared-memory multicycle MIPS datapath for the team's subset: R-type (000000), addi (001000), lw (100011), sw (101011), beq (000100), j (000010).
- Generates per-cycle datapath enables and mux selects.
- Waits on a single shared instruction/data memory through a request/acknowledge handshake.
- Counts retired instructions and flags illegal opcodes.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- Op_i  input  6  opcode field from the instruction register.
- mem_ack_i  input  1  memory completes the current read/write this cycle.
- PCWrite_o  output  1  unconditional PC load.
- PCWriteCond_o  output  1  PC load gated by ALU zero (beq).
- IorD_o  output  1  memory address select: 0=PC, 1=ALUOut.
- MemRd_o  output  1  memory read request.
- MemWr_o  output  1  memory write request.
- IRWrite_o  output  1  instruction register load.
- MemtoReg_o  output  1  write-back select: 1=MDR, 0=ALUOut.
- RegDst_o  output  1  destination register select: 1=rd, 0=rt.
- RegWrite_o  output  1  register file write.
- ALUSrcA_o  output  1  ALU A select: 0=PC, 1=rs.
- ALUSrcB_o  output  2  ALU B select: 00=rt, 01=4, 10=signext imm, 11=signext imm<<2.
- ALUOp_o  output  2  ALU op: 00=add, 01=sub, 10=funct.
- PCSource_o  output  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
- illegal_o  output  1  one-cycle pulse on an undecoded opcode.
- retired_o  output  CNT_W  retired-instruction count.

Behaviour:
- States (4-bit encoding): FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, ADDI_EX, ADDI_WB, BRANCH, JUMP.
- Reset (rst_i low, asynchronous): state=FETCH, retired_o=0, latched opcode=0. All outputs are decoded from state, so every output takes its FETCH value.
- Output defaults: every output is 0 unless listed for the current state.
- FETCH: MemRd=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - mem_ack_i=1: IRWrite=1 and PCWrite=1 in the same cycle (Mealy), next DECODE.
  - mem_ack_i=0: stay in FETCH, IRWrite and PCWrite stay 0.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precomputes the branch target).
  - Latch Op_i into an internal register; later states decode only the latched copy.
  - Next state: lw/sw -> MEMADR, R-type -> EXEC, addi -> ADDI_EX, beq -> BRANCH, j -> JUMP.
  - Any other opcode: illegal_o=1 this cycle, next FETCH, no retire.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next MEMRD if latched opcode is lw, else MEMWR.
- MEMRD: MemRd=1, IorD=1. Stay until mem_ack_i=1, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Retire, next FETCH.
- MEMWR: MemWr=1, IorD=1. Stay until mem_ack_i=1; retire in that cycle, next FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. Retire, next FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0. Retire, next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Retire, next FETCH.
- JUMP: PCWrite=1, PCSource=10. Retire, next FETCH.
- Latency with zero-wait memory (cycles from FETCH entry back to FETCH):
  - lw 5; R-type, addi and sw 4; beq and j 3.
  - Each wait cycle adds one cycle.
- Retire: retired_o increments by 1 on the clock edge leaving a retiring state. It wraps from 2^CNT_W-1 to 0 with no flag.
- Memory requests:
  - MemRd_o/MemWr_o stay asserted until acknowledged; they are never both 1.
  - mem_ack_i is ignored in every state except FETCH, MEMRD and MEMWR.
- Reset mid-operation (any state, including mid-wait): immediate return to FETCH and retired_o=0. No partial write enable survives, because all outputs are decoded from state.
- No unreachable-state lockup: any unused encoding returns to FETCH on the next edge, with all outputs 0.

Test Plan:
- Reset: assert rst_i low mid-clock -> MemRd_o=1, ALUSrcB_o=01, all other outputs 0, retired_o=0 without waiting for a clock edge.
- R-type, Op_i=000000, mem_ack_i tied 1:
  - States FETCH, DECODE, EXEC, RWB.
  - RegWrite_o=1 and RegDst_o=1 in cycle 4.
  - retired_o 0 -> 1.
- lw, Op_i=100011, mem_ack_i=0 for 2 cycles in MEMRD:
  - MemRd_o=1 and IorD_o=1 held for 3 cycles.
  - Then MEMWB with MemtoReg_o=1; total 7 cycles.
- beq then j, zero-wait:
  - BRANCH cycle: PCWriteCond_o=1, PCSource_o=01, ALUOp_o=01.
  - JUMP cycle: PCWrite_o=1, PCSource_o=10.
  - retired_o +2 over 6 cycles.
- Illegal Op_i=111111 -> illegal_o=1 for exactly one cycle in DECODE, return to FETCH, retired_o unchanged.
- Reset during MEMWR wait -> MemWr_o drops immediately; FETCH after release. Separately, with CNT_W=2, retire 4 instructions -> retired_o 3 -> 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Control FSM for a shared-memory multicycle MIPS datapath (R-type, addi, lw, sw, beq, j).
// Drives datapath enables/selects, handshakes with the unified memory and counts retirements.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       Op_i,
    input  logic             mem_ack_i,
    output logic             PCWrite_o,
    output logic             PCWriteCond_o,
    output logic             IorD_o,
    output logic             MemRd_o,
    output logic             MemWr_o,
    output logic             IRWrite_o,
    output logic             MemtoReg_o,
    output logic             RegDst_o,
    output logic             RegWrite_o,
    output logic             ALUSrcA_o,
    output logic [1:0]       ALUSrcB_o,
    output logic [1:0]       ALUOp_o,
    output logic [1:0]       PCSource_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXEC    = 4'd6;
    localparam logic [3:0] S_RWB     = 4'd7;
    localparam logic [3:0] S_ADDI_EX = 4'd8;
    localparam logic [3:0] S_ADDI_WB = 4'd9;
    localparam logic [3:0] S_BRANCH  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [3:0]       state_r;
    logic [3:0]       next_state_s;
    logic [5:0]       op_r;
    logic             retire_s;
    logic [CNT_W-1:0] retired_r;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Opcode latch: captured in DECODE so later states ignore IR changes
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_r <= 6'd0;
        end else if (state_r == S_DECODE) begin
            op_r <= Op_i;
        end else begin
            op_r <= op_r;
        end
    end

    // Retired-instruction counter, wraps silently
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            retired_r <= '0;
        end else if (retire_s) begin
            retired_r <= retired_r + CNT_W'(1);
        end else begin
            retired_r <= retired_r;
        end
    end

    // Next-state logic; DECODE dispatches on the live opcode, MEMADR on the latched one
    always_comb begin
        next_state_s = S_FETCH;
        case (state_r)
            S_FETCH:   next_state_s = mem_ack_i ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op_i)
                    OP_LW, OP_SW: next_state_s = S_MEMADR;
                    OP_RTYPE:     next_state_s = S_EXEC;
                    OP_ADDI:      next_state_s = S_ADDI_EX;
                    OP_BEQ:       next_state_s = S_BRANCH;
                    OP_J:         next_state_s = S_JUMP;
                    default:      next_state_s = S_FETCH;
                endcase
            end
            S_MEMADR:  next_state_s = (op_r == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   next_state_s = mem_ack_i ? S_MEMWB : S_MEMRD;
            S_MEMWB:   next_state_s = S_FETCH;
            S_MEMWR:   next_state_s = mem_ack_i ? S_FETCH : S_MEMWR;
            S_EXEC:    next_state_s = S_RWB;
            S_RWB:     next_state_s = S_FETCH;
            S_ADDI_EX: next_state_s = S_ADDI_WB;
            S_ADDI_WB: next_state_s = S_FETCH;
            S_BRANCH:  next_state_s = S_FETCH;
            S_JUMP:    next_state_s = S_FETCH;
            default:   next_state_s = S_FETCH;
        endcase
    end

    // Output decode; only FETCH/MEMWR (ack) and DECODE (opcode) have Mealy terms
    always_comb begin
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        IorD_o        = 1'b0;
        MemRd_o       = 1'b0;
        MemWr_o       = 1'b0;
        IRWrite_o     = 1'b0;
        MemtoReg_o    = 1'b0;
        RegDst_o      = 1'b0;
        RegWrite_o    = 1'b0;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = 2'b00;
        ALUOp_o       = 2'b00;
        PCSource_o    = 2'b00;
        illegal_o     = 1'b0;
        retire_s      = 1'b0;
        case (state_r)
            S_FETCH: begin
                MemRd_o   = 1'b1;
                ALUSrcB_o = 2'b01;
                IRWrite_o = mem_ack_i;
                PCWrite_o = mem_ack_i;
            end
            S_DECODE: begin
                ALUSrcB_o = 2'b11;
                case (Op_i)
                    OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_BEQ, OP_J: illegal_o = 1'b0;
                    default:                                       illegal_o = 1'b1;
                endcase
            end
            S_MEMADR, S_ADDI_EX: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
            end
            S_MEMRD: begin
                MemRd_o = 1'b1;
                IorD_o  = 1'b1;
            end
            S_MEMWB: begin
                RegWrite_o = 1'b1;
                MemtoReg_o = 1'b1;
                retire_s   = 1'b1;
            end
            S_MEMWR: begin
                MemWr_o  = 1'b1;
                IorD_o   = 1'b1;
                retire_s = mem_ack_i;
            end
            S_EXEC: begin
                ALUSrcA_o = 1'b1;
                ALUOp_o   = 2'b10;
            end
            S_RWB: begin
                RegWrite_o = 1'b1;
                RegDst_o   = 1'b1;
                retire_s   = 1'b1;
            end
            S_ADDI_WB: begin
                RegWrite_o = 1'b1;
                retire_s   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA_o     = 1'b1;
                ALUOp_o       = 2'b01;
                PCWriteCond_o = 1'b1;
                PCSource_o    = 2'b01;
                retire_s      = 1'b1;
            end
            S_JUMP: begin
                PCWrite_o  = 1'b1;
                PCSource_o = 2'b10;
                retire_s   = 1'b1;
            end
            default: begin
                retire_s = 1'b0;
            end
        endcase
    end

    assign retired_o = retired_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle control-word checks against hand-built tables,
// plus a 2-bit counter instance sharing the same stimulus to show wrap-around.
module tb_multicycle_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [5:0]  Op_i = 6'd0;
    logic        mem_ack_i = 1'b0;

    logic PCWrite_o, PCWriteCond_o, IorD_o, MemRd_o, MemWr_o, IRWrite_o;
    logic MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, illegal_o;
    logic [1:0] ALUSrcB_o, ALUOp_o, PCSource_o;
    logic [31:0] retired_o;

    logic b_PCWrite, b_PCWriteCond, b_IorD, b_MemRd, b_MemWr, b_IRWrite;
    logic b_MemtoReg, b_RegDst, b_RegWrite, b_ALUSrcA, b_illegal;
    logic [1:0] b_ALUSrcB, b_ALUOp, b_PCSource;
    logic [1:0] b_retired;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_ret = 32'd0;

    // Control word: PCWrite,PCWriteCond,IorD,MemRd,MemWr,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB[2],ALUOp[2],PCSource[2],illegal
    logic [16:0] ctl, ctl_b;
    assign ctl   = {PCWrite_o, PCWriteCond_o, IorD_o, MemRd_o, MemWr_o, IRWrite_o, MemtoReg_o,
                    RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, PCSource_o, illegal_o};
    assign ctl_b = {b_PCWrite, b_PCWriteCond, b_IorD, b_MemRd, b_MemWr, b_IRWrite, b_MemtoReg,
                    b_RegDst, b_RegWrite, b_ALUSrcA, b_ALUSrcB, b_ALUOp, b_PCSource, b_illegal};

    localparam logic [16:0] C_FETCH   = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_FETCH_A = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_DECODE  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] C_DEC_ILL = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
    localparam logic [16:0] C_MEMADR  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] C_MEMRD   = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_MEMWB   = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] C_MEMWR   = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_EXEC    = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] C_RWB     = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] C_ADDI_WB = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
    localparam logic [16:0] C_BRANCH  = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] C_JUMP    = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;

    localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010;

    logic [5:0]  seq_op  [16];
    logic        seq_ack [16];
    logic [16:0] seq_exp [16];
    int          seq_len;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .Op_i(Op_i), .mem_ack_i(mem_ack_i),
        .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o), .IorD_o(IorD_o),
        .MemRd_o(MemRd_o), .MemWr_o(MemWr_o), .IRWrite_o(IRWrite_o),
        .MemtoReg_o(MemtoReg_o), .RegDst_o(RegDst_o), .RegWrite_o(RegWrite_o),
        .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .ALUOp_o(ALUOp_o),
        .PCSource_o(PCSource_o), .illegal_o(illegal_o), .retired_o(retired_o)
    );

    multicycle_ctrl #(.CNT_W(2)) dut_w2 (
        .clk_i(clk_i), .rst_i(rst_i), .Op_i(Op_i), .mem_ack_i(mem_ack_i),
        .PCWrite_o(b_PCWrite), .PCWriteCond_o(b_PCWriteCond), .IorD_o(b_IorD),
        .MemRd_o(b_MemRd), .MemWr_o(b_MemWr), .IRWrite_o(b_IRWrite),
        .MemtoReg_o(b_MemtoReg), .RegDst_o(b_RegDst), .RegWrite_o(b_RegWrite),
        .ALUSrcA_o(b_ALUSrcA), .ALUSrcB_o(b_ALUSrcB), .ALUOp_o(b_ALUOp),
        .PCSource_o(b_PCSource), .illegal_o(b_illegal), .retired_o(b_retired)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Each cycle: drive inputs 1ns after the edge, check 1ns later, then advance
    task automatic run_table(input string name);
        for (int i = 0; i < seq_len; i++) begin
            Op_i = seq_op[i];
            mem_ack_i = seq_ack[i];
            #1;
            checks++;
            if (ctl !== seq_exp[i]) begin
                failures++;
                $display("FAIL %s cycle %0d ctl: got %b expected %b", name, i, ctl, seq_exp[i]);
            end
            checks++;
            if (ctl_b !== seq_exp[i]) begin
                failures++;
                $display("FAIL %s cycle %0d ctl_w2: got %b expected %b", name, i, ctl_b, seq_exp[i]);
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic check_retired(input string name);
        #1;
        checks++;
        if (retired_o !== exp_ret) begin
            failures++;
            $display("FAIL %s retired: got %0d expected %0d", name, retired_o, exp_ret);
        end
        checks++;
        if (b_retired !== exp_ret[1:0]) begin
            failures++;
            $display("FAIL %s retired_w2: got %0d expected %0d", name, b_retired, exp_ret[1:0]);
        end
        checks++;
        mem_ack_i = 1'b0;
        #1;
        if (ctl !== C_FETCH) begin
            failures++;
            $display("FAIL %s back_in_fetch: got %b expected %b", name, ctl, C_FETCH);
        end
        #(-2 + 2);
    endtask

    task automatic test_reset();
        #3 rst_i = 1'b0;
        #1;
        checks++;
        if (ctl !== C_FETCH) begin
            failures++;
            $display("FAIL reset ctl: got %b expected %b", ctl, C_FETCH);
        end
        checks++;
        if (retired_o !== 32'd0 || b_retired !== 2'd0) begin
            failures++;
            $display("FAIL reset retired: got %0d/%0d expected 0", retired_o, b_retired);
        end
        @(negedge clk_i) rst_i = 1'b1;
        @(posedge clk_i); #1;
        exp_ret = 32'd0;
    endtask

    task automatic test_rtype();
        seq_len = 4;
        seq_op  = '{default: OP_R};
        seq_ack = '{default: 1'b1};
        seq_exp[0] = C_FETCH_A; seq_exp[1] = C_DECODE; seq_exp[2] = C_EXEC; seq_exp[3] = C_RWB;
        run_table("rtype");
        exp_ret = exp_ret + 32'd1;
        check_retired("rtype");
        @(posedge clk_i); #1;
    endtask

    task automatic test_lw_wait();
        seq_len = 7;
        seq_op  = '{default: OP_LW};
        seq_ack = '{default: 1'b1};
        seq_ack[3] = 1'b0; seq_ack[4] = 1'b0;
        seq_exp[0] = C_FETCH_A; seq_exp[1] = C_DECODE; seq_exp[2] = C_MEMADR;
        seq_exp[3] = C_MEMRD; seq_exp[4] = C_MEMRD; seq_exp[5] = C_MEMRD; seq_exp[6] = C_MEMWB;
        run_table("lw_wait");
        exp_ret = exp_ret + 32'd1;
        check_retired("lw_wait");
        @(posedge clk_i); #1;
    endtask

    task automatic test_sw_addi();
        seq_len = 8;
        seq_op  = '{default: OP_SW};
        seq_ack = '{default: 1'b1};
        for (int i = 4; i < 8; i++) seq_op[i] = OP_ADDI;
        seq_exp[0] = C_FETCH_A; seq_exp[1] = C_DECODE; seq_exp[2] = C_MEMADR; seq_exp[3] = C_MEMWR;
        seq_exp[4] = C_FETCH_A; seq_exp[5] = C_DECODE; seq_exp[6] = C_MEMADR; seq_exp[7] = C_ADDI_WB;
        run_table("sw_addi");
        exp_ret = exp_ret + 32'd2;
        check_retired("sw_addi");
        @(posedge clk_i); #1;
    endtask

    task automatic test_beq_j();
        seq_len = 6;
        seq_op  = '{default: OP_BEQ};
        seq_ack = '{default: 1'b1};
        for (int i = 3; i < 6; i++) seq_op[i] = OP_J;
        seq_exp[0] = C_FETCH_A; seq_exp[1] = C_DECODE; seq_exp[2] = C_BRANCH;
        seq_exp[3] = C_FETCH_A; seq_exp[4] = C_DECODE; seq_exp[5] = C_JUMP;
        run_table("beq_j");
        exp_ret = exp_ret + 32'd2;
        check_retired("beq_j");
        @(posedge clk_i); #1;
    endtask

    task automatic test_illegal();
        seq_len = 2;
        seq_op  = '{default: 6'b111111};
        seq_ack = '{default: 1'b1};
        seq_exp[0] = C_FETCH_A; seq_exp[1] = C_DEC_ILL;
        run_table("illegal");
        check_retired("illegal");
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset_mid_write();
        seq_len = 4;
        seq_op  = '{default: OP_SW};
        seq_ack = '{default: 1'b1};
        seq_ack[3] = 1'b0;
        seq_exp[0] = C_FETCH_A; seq_exp[1] = C_DECODE; seq_exp[2] = C_MEMADR; seq_exp[3] = C_MEMWR;
        run_table("rst_memwr");
        // now second MEMWR wait cycle
        mem_ack_i = 1'b0;
        #1;
        checks++;
        if (MemWr_o !== 1'b1) begin
            failures++;
            $display("FAIL rst_memwr pre MemWr: got %b expected 1", MemWr_o);
        end
        rst_i = 1'b0;
        #1;
        checks++;
        if (ctl !== C_FETCH || retired_o !== 32'd0) begin
            failures++;
            $display("FAIL rst_memwr during reset: ctl %b ret %0d expected %b ret 0", ctl, retired_o, C_FETCH);
        end
        @(negedge clk_i) rst_i = 1'b1;
        @(posedge clk_i); #1;
        exp_ret = 32'd0;
        checks++;
        if (ctl !== C_FETCH) begin
            failures++;
            $display("FAIL rst_memwr after release: got %b expected %b", ctl, C_FETCH);
        end
    endtask

    task automatic test_wrap();
        logic [1:0] exp_w [4];
        exp_w[0] = 2'd1; exp_w[1] = 2'd2; exp_w[2] = 2'd3; exp_w[3] = 2'd0;
        for (int k = 0; k < 4; k++) begin
            Op_i = OP_R;
            mem_ack_i = 1'b1;
            repeat (4) @(posedge clk_i);
            #1;
            exp_ret = exp_ret + 32'd1;
            checks++;
            if (b_retired !== exp_w[k]) begin
                failures++;
                $display("FAIL wrap step %0d retired_w2: got %0d expected %0d", k, b_retired, exp_w[k]);
            end
        end
        checks++;
        if (retired_o !== 32'd4) begin
            failures++;
            $display("FAIL wrap retired32: got %0d expected 4", retired_o);
        end
        mem_ack_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw_addi();
        test_beq_j();
        test_illegal();
        test_reset_mid_write();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
